// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and rd_wr polarity for the SRAM column sequencer
package sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WL,
      REC,
      DONE
   } sram_state_e;

   localparam logic RDWR_READ  = 1'b1;
   localparam logic RDWR_WRITE = 1'b0;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter with zero flag that times each access phase
module sram_phase_timer #(
   parameter int MAX_CNT = 2,
   parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Saturates at zero so a phase that overstays never wraps into a long count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word request sequencer driving precharge, write driver, wordline and read capture
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 1,
   parameter int ADDR_W    = 2,
   parameter int SETUP_CYC = 2,
   parameter int WL_CYC    = 2,
   parameter int REC_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [COLS-1:0]   req_wdata,
   output logic [ROWS-1:0]   row,
   output logic              rd_wr,
   output logic [COLS-1:0]   data_in,
   input  logic [COLS-1:0]   preout,
   output logic [COLS-1:0]   rd_data,
   output logic              done,
   output logic              rd_valid,
   output logic              err
);

   localparam int MAX_PH = (SETUP_CYC > WL_CYC) ?
                           ((SETUP_CYC > REC_CYC) ? SETUP_CYC : REC_CYC) :
                           ((WL_CYC > REC_CYC) ? WL_CYC : REC_CYC);
   localparam int CNT_W = $clog2(MAX_PH + 1);
   localparam logic [ADDR_W:0] ROWS_LIM = (ADDR_W + 1)'(ROWS);

   sram_state_e       r_state;
   sram_state_e       w_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [COLS-1:0]   r_data_in;
   logic [COLS-1:0]   r_rd_data;
   logic              w_load;
   logic [CNT_W-1:0]  w_load_val;
   logic              w_zero;
   logic              w_oor;
   logic [ROWS-1:0]   w_row_hot;

   assign w_oor     = ({1'b0, r_addr} >= ROWS_LIM);
   assign w_row_hot = ROWS'(1) << r_addr;

   sram_phase_timer #(
      .MAX_CNT (MAX_PH),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The timer is reloaded with the new phase length on every state change.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_next = SETUP;
         SETUP:   if (w_zero) w_next = WL;
         WL:      if (w_zero) w_next = REC;
         REC:     if (w_zero) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      w_load = (w_next != r_state);
      case (w_next)
         SETUP:   w_load_val = CNT_W'(SETUP_CYC - 1);
         WL:      w_load_val = CNT_W'(WL_CYC - 1);
         REC:     w_load_val = CNT_W'(REC_CYC - 1);
         default: w_load_val = '0;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rd_wr     = RDWR_READ;
      row       = '0;
      done      = 1'b0;
      rd_valid  = 1'b0;
      err       = 1'b0;
      case (r_state)
         IDLE:       req_ready = 1'b1;
         SETUP, REC: rd_wr = r_we ? RDWR_WRITE : RDWR_READ;
         WL: begin
            rd_wr = r_we ? RDWR_WRITE : RDWR_READ;
            if (!w_oor) row = w_row_hot;
         end
         DONE: begin
            done     = 1'b1;
            rd_valid = ~r_we;
            err      = w_oor;
         end
         default: ;
      endcase
   end

   // Read data is sampled on the edge that drops the wordline, while the sense amp is still valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data_in <= '0;
         r_rd_data <= '0;
      end else begin
         if (r_state == IDLE && req_valid) begin
            r_we   <= req_we;
            r_addr <= req_addr;
            if (req_we) r_data_in <= req_wdata;
         end
         if (r_state == WL && w_zero && !r_we) begin
            r_rd_data <= w_oor ? '0 : preout;
         end
      end
   end

   assign data_in = r_data_in;
   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
module tb_sram_ctrl;

   localparam int ROWS   = 4;
   localparam int COLS   = 1;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [COLS-1:0]   req_wdata;
   logic [ROWS-1:0]   row;
   logic              rd_wr;
   logic [COLS-1:0]   data_in;
   logic [COLS-1:0]   preout;
   logic [COLS-1:0]   rd_data;
   logic              done;
   logic              rd_valid;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [ROWS-1:0] prev_row = '0;
   logic            prev_rdwr = 1'b1;

   // {req_ready, row[3:0], rd_wr, data_in, done, rd_valid, err, rd_data}
   logic [10:0] obs;
   assign obs = {req_ready, row, rd_wr, data_in, done, rd_valid, err, rd_data};

   sram_ctrl #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .ADDR_W    (ADDR_W),
      .SETUP_CYC (2),
      .WL_CYC    (2),
      .REC_CYC   (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .row       (row),
      .rd_wr     (rd_wr),
      .data_in   (data_in),
      .preout    (preout),
      .rd_data   (rd_data),
      .done      (done),
      .rd_valid  (rd_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (row !== '0) begin
            checks++;
            if (((row & (row - 1'b1)) !== '0) || (prev_row !== '0 && rd_wr !== prev_rdwr)) begin
               errors++;
               $display("FAIL invariant: row %b rd_wr %b, previous row %b rd_wr %b", row, rd_wr, prev_row, prev_rdwr);
            end
         end
         prev_row  = row;
         prev_rdwr = rd_wr;
      end else begin
         prev_row  = '0;
         prev_rdwr = 1'b1;
      end
   end

   task automatic start_req(input logic we, input logic [ADDR_W-1:0] addr, input logic wd);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
   endtask

   task automatic test_reset();
      logic [10:0] exp;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; preout = '0;
      @(negedge clk);
      @(negedge clk);
      exp = {1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset: got %b want %b", obs, exp);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      logic [10:0] exp;
      start_req(1'b1, 3'd2, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k == 7), ((k == 3 || k == 4) ? 4'b0100 : 4'b0000), (k > 5), 1'b1,
                (k == 6), 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL write cyc %0d: got %b want %b", k, obs, exp);
         end
         if (k == 1) req_valid = 1'b0;
      end
   endtask

   task automatic test_read();
      logic [10:0] exp;
      preout = 1'b1;
      start_req(1'b0, 3'd2, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k == 7), ((k == 3 || k == 4) ? 4'b0100 : 4'b0000), 1'b1, 1'b1,
                (k == 6), (k == 6), 1'b0, (k >= 5)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL read cyc %0d: got %b want %b", k, obs, exp);
         end
         if (k == 1) req_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp;
      preout = 1'b0;
      start_req(1'b1, 3'd2, 1'b0);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         exp = {(k == 7 || k == 14),
                ((k == 3 || k == 4 || k == 10 || k == 11) ? 4'b0100 : 4'b0000),
                (k > 5), 1'b0, (k == 6 || k == 13), (k == 13), 1'b0, (k < 12)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %b want %b", k, obs, exp);
         end
         if (k == 1) begin
            req_we    = 1'b0;
            req_wdata = 1'b1;
         end
         if (k == 8) req_valid = 1'b0;
      end
   endtask

   task automatic test_toggle();
      logic [10:0] exp;
      preout = 1'b1;
      start_req(1'b0, 3'd1, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k == 7), ((k == 3 || k == 4) ? 4'b0010 : 4'b0000), 1'b1, 1'b0,
                (k == 6), (k == 6), 1'b0, (k >= 5)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL toggle cyc %0d: got %b want %b", k, obs, exp);
         end
         if (k == 1) begin
            req_valid = 1'b0;
            req_we    = 1'b1;
            req_addr  = 3'd3;
            req_wdata = 1'b1;
         end
         if (k == 3) req_addr = 3'd0;
      end
   endtask

   task automatic test_out_of_range();
      logic [10:0] exp;
      preout = 1'b1;
      start_req(1'b0, 3'd5, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k == 7), 4'b0000, 1'b1, 1'b0, (k == 6), (k == 6), (k == 6), (k < 5)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL out_of_range cyc %0d: got %b want %b", k, obs, exp);
         end
         if (k == 1) req_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] exp;
      preout = 1'b0;
      start_req(1'b1, 3'd1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
      end
      checks++;
      if (row !== 4'b0010) begin
         errors++;
         $display("FAIL reset_mid_wl row: got %b want %b", row, 4'b0010);
      end
      #2 rst_n = 1'b0;
      #1;
      exp = {1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_mid_async: got %b want %b", obs, exp);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_after cyc %0d: got %b want %b", k, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_toggle();
      test_out_of_range();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
